// File: rtl/pipelined_reduce_pkg.sv
// Shared opcodes and tree-sizing helpers for the pipelined reduction gate.
// Optional sticky-hit logic in the top is enabled by defining PRG_STICKY_EN.
package pipelined_reduce_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // Number of FANIN-ary levels needed to fold width bits down to one; never less than 1.
  function automatic int clog_fanin(input int width, input int fanin);
    int n;
    int s;
    n = width;
    s = 0;
    while (n > 1) begin
      n = (n + fanin - 1) / fanin;
      s = s + 1;
    end
    if (s < 1) s = 1;
    return s;
  endfunction

  // Node count entering tree level 'level' (level 0 is the raw operand).
  function automatic int nodes_at(input int width, input int fanin, input int level);
    int n;
    n = width;
    for (int k = 0; k < level; k++) begin
      n = (n + fanin - 1) / fanin;
    end
    return n;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One registered FANIN-ary reduction level; chunks are taken LSB first and the short
// tail chunk is padded with the operation identity. The LAST level applies NAND inversion.
module reduce_stage
  import pipelined_reduce_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int FANIN = 4,
  parameter bit LAST  = 1'b0
) (
  input  logic                              CK,
  input  logic                              RSTN,
  input  logic                              CE,
  input  logic                              vi,
  input  logic [1:0]                        op,
  input  logic [IN_W-1:0]                   d,
  output logic                              vo,
  output logic [1:0]                        op_o,
  output logic [(IN_W+FANIN-1)/FANIN-1:0]   q,
  output logic                              hit
);

  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN;
  localparam int PAD_W = OUT_W * FANIN;

  logic             ident;
  logic [PAD_W-1:0] dp;
  logic [OUT_W-1:0] red;
  logic [OUT_W-1:0] q_nxt;

  always_comb begin
    ident = (op == OP_AND) || (op == OP_NAND);
    dp    = {PAD_W{ident}};
    dp[IN_W-1:0] = d;
    red   = '0;
    for (int j = 0; j < OUT_W; j++) begin
      case (op)
        OP_OR:   red[j] = |dp[j*FANIN +: FANIN];
        OP_XOR:  red[j] = ^dp[j*FANIN +: FANIN];
        default: red[j] = &dp[j*FANIN +: FANIN];
      endcase
    end
    q_nxt = red;
    if (LAST && (op == OP_NAND)) q_nxt = ~red;
  end

  // Only meaningful on the final level, where q_nxt is the single result bit.
  assign hit = vi & q_nxt[0];

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      vo   <= 1'b0;
      op_o <= OP_AND;
      q    <= '0;
    end else if (CE) begin
      vo   <= vi;
      op_o <= op;
      // The final result only moves on valid slots so Z holds across bubbles.
      if (!LAST || vi) q <= q_nxt;
    end
  end

endmodule

// File: rtl/pipelined_reduce_gate.sv
// WIDTH-input AND/OR/XOR/NAND reduction as a registered FANIN-ary tree, latency STAGES, CE stalls all.
// Define PRG_STICKY_EN to add the ZS sticky-hit flag and its CLR input.
module pipelined_reduce_gate
  import pipelined_reduce_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FANIN = 4
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             CE,
  input  logic             VI,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  output logic             VO,
  output logic             Z
`ifdef PRG_STICKY_EN
  ,
  output logic             ZS,
  input  logic             CLR
`endif
);

  localparam int STAGES = clog_fanin(WIDTH, FANIN);

  logic [WIDTH-1:0] dat [0:STAGES];
  logic [1:0]       ops [0:STAGES];
  logic [STAGES:0]  vld;
  logic [STAGES:1]  hits;

  assign dat[0] = A;
  assign ops[0] = OP;
  assign vld[0] = VI;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = nodes_at(WIDTH, FANIN, k);
    localparam int OW = nodes_at(WIDTH, FANIN, k + 1);

    logic [OW-1:0] q;
    logic          unused_dat;

    reduce_stage #(
      .IN_W  (IW),
      .FANIN (FANIN),
      .LAST  (k == STAGES - 1)
    ) u_stage (
      .CK   (CK),
      .RSTN (RSTN),
      .CE   (CE),
      .vi   (vld[k]),
      .op   (ops[k]),
      .d    (dat[k][IW-1:0]),
      .vo   (vld[k+1]),
      .op_o (ops[k+1]),
      .q    (q),
      .hit  (hits[k+1])
    );

    assign dat[k+1]   = WIDTH'(q);
    assign unused_dat = ^dat[k+1];
  end

  assign VO = vld[STAGES];
  assign Z  = dat[STAGES][0];

  logic unused_top;
  assign unused_top = ^{ops[STAGES], hits};

`ifdef PRG_STICKY_EN
  logic zs_q;

  // A hit landing on the same edge as CLR wins; CLR alone works even while stalled.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      zs_q <= 1'b0;
    end else if (CE && hits[STAGES]) begin
      zs_q <= 1'b1;
    end else if (CLR) begin
      zs_q <= 1'b0;
    end
  end

  assign ZS = zs_q;
`endif

endmodule

// File: tb/tb_pipelined_reduce_gate.sv
// Directed bench: WIDTH=16/FANIN=4 (2 stages) and WIDTH=5/FANIN=2 (3 stages, padded tail chunks).
module tb_pipelined_reduce_gate;

  logic        CK = 1'b0;
  logic        RSTN, CE, VI;
  logic [1:0]  OP;
  logic [15:0] A;
  logic [4:0]  A2;
  logic        VO, Z, VO2, Z2;
  int          errs = 0;
  int          checks = 0;
`ifdef PRG_STICKY_EN
  logic        CLR, ZS, ZS2;
`endif

  localparam logic [1:0] AND_ = 2'b00, OR_ = 2'b01, XOR_ = 2'b10, NAND_ = 2'b11;

  always #5 CK = ~CK;

  pipelined_reduce_gate #(.WIDTH(16), .FANIN(4)) dut (
    .CK(CK), .RSTN(RSTN), .CE(CE), .VI(VI), .OP(OP), .A(A), .VO(VO), .Z(Z)
`ifdef PRG_STICKY_EN
    , .ZS(ZS), .CLR(CLR)
`endif
  );

  pipelined_reduce_gate #(.WIDTH(5), .FANIN(2)) dut2 (
    .CK(CK), .RSTN(RSTN), .CE(CE), .VI(VI), .OP(OP), .A(A2), .VO(VO2), .Z(Z2)
`ifdef PRG_STICKY_EN
    , .ZS(ZS2), .CLR(CLR)
`endif
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic put(input logic v, input logic [1:0] o, input logic [15:0] a);
    VI = v;
    OP = o;
    A  = a;
  endtask

  initial begin
    RSTN = 1'b0; CE = 1'b1; A2 = '0;
`ifdef PRG_STICKY_EN
    CLR = 1'b0;
`endif
    put(1'b1, AND_, 16'hFFFF);

    // Reset dominates with valid input present.
    tick(); chk("rst_vo_0", VO, 1'b0); chk("rst_z_0", Z, 1'b0);
    tick(); chk("rst_vo_1", VO, 1'b0); chk("rst_z_1", Z, 1'b0);
    chk("rst_vo2", VO2, 1'b0);
`ifdef PRG_STICKY_EN
    chk("rst_zs", ZS, 1'b0);
`endif
    RSTN = 1'b1; VI = 1'b0;
    tick(); chk("post_rst_vo_0", VO, 1'b0); chk("post_rst_z_0", Z, 1'b0);
    tick(); chk("post_rst_vo_1", VO, 1'b0); chk("post_rst_z_1", Z, 1'b0);

    // Back-to-back AND then OR.
    put(1'b1, AND_, 16'hFFFF); tick(); chk("b2b_vo_e1", VO, 1'b0);
    put(1'b1, AND_, 16'hFFFE); tick(); chk("b2b_vo_e2", VO, 1'b1); chk("b2b_z_ffff", Z, 1'b1);
    put(1'b1, OR_,  16'h0000); tick(); chk("b2b_vo_e3", VO, 1'b1); chk("b2b_z_fffe", Z, 1'b0);
    put(1'b1, OR_,  16'h0100); tick(); chk("b2b_vo_e4", VO, 1'b1); chk("b2b_z_0000", Z, 1'b0);
    put(1'b0, OR_,  16'h0000); tick(); chk("b2b_vo_e5", VO, 1'b1); chk("b2b_z_0100", Z, 1'b1);
    put(1'b0, AND_, 16'h0000); tick(); chk("b2b_vo_bub", VO, 1'b0); chk("b2b_z_hold", Z, 1'b1);

    // XOR and NAND with final-stage inversion.
    put(1'b1, XOR_,  16'h0007); tick();
    put(1'b1, NAND_, 16'hFFFF); tick(); chk("xor_0007", Z, 1'b1); chk("xor_vo", VO, 1'b1);
    put(1'b1, NAND_, 16'h7FFF); tick(); chk("nand_ffff", Z, 1'b0);
    put(1'b0, NAND_, 16'h0000); tick(); chk("nand_7fff", Z, 1'b1);
    tick(); chk("nand_vo_end", VO, 1'b0);

    // CE stall: result appears on the second enabled edge, Z frozen meanwhile.
    put(1'b1, AND_, 16'hFFFE); tick(); chk("ce_vo_e1", VO, 1'b0);
    VI = 1'b0; CE = 1'b0; A = 16'h1234; OP = OR_;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("ce_stall_vo", VO, 1'b0); chk("ce_stall_z", Z, 1'b1);
    end
    CE = 1'b1;
    tick(); chk("ce_vo_e2", VO, 1'b1); chk("ce_z_fffe", Z, 1'b0);
    tick(); chk("ce_vo_after", VO, 1'b0);

    // OP change between consecutive items.
    put(1'b1, AND_, 16'hFFFF); tick();
    put(1'b1, OR_,  16'h0000); tick(); chk("opchg_vo1", VO, 1'b1); chk("opchg_z_and", Z, 1'b1);
    put(1'b0, AND_, 16'hFFFF); tick(); chk("opchg_vo2", VO, 1'b1); chk("opchg_z_or", Z, 1'b0);
    A = 16'hFFFF; tick(); chk("bubble_vo", VO, 1'b0); chk("bubble_z_hold", Z, 1'b0);

    // Reset mid-flight discards the in-flight item.
    put(1'b1, AND_, 16'hFFFF); tick();
    RSTN = 1'b0; VI = 1'b0; tick(); chk("rstmid_vo", VO, 1'b0); chk("rstmid_z", Z, 1'b0);
    RSTN = 1'b1; tick(); chk("rstmid_vo_after", VO, 1'b0);

    // Three-stage tree with padded tail chunks.
    put(1'b1, OR_, 16'h0000); A2 = 5'b10000; tick(); chk("w5_vo_e1", VO2, 1'b0);
    VI = 1'b0; A2 = 5'b00000;                tick(); chk("w5_vo_e2", VO2, 1'b0);
    tick(); chk("w5_vo_e3", VO2, 1'b1); chk("w5_or_10000", Z2, 1'b1);
    put(1'b1, AND_, 16'h0000); A2 = 5'b01111; tick();
    A2 = 5'b11111; tick();
    VI = 1'b0; tick(); chk("w5_and_vo", VO2, 1'b1); chk("w5_and_01111", Z2, 1'b0);
    tick(); chk("w5_and_11111", Z2, 1'b1);
    tick(); chk("w5_vo_end", VO2, 1'b0);

`ifdef PRG_STICKY_EN
    CLR = 1'b1; tick(); CLR = 1'b0; chk("zs_clr0", ZS, 1'b0);
    put(1'b1, AND_, 16'hFFFF); tick();
    put(1'b1, AND_, 16'h0000); tick(); chk("zs_set", ZS, 1'b1);
    VI = 1'b0; tick(); chk("zs_hold", ZS, 1'b1); chk("zs_hold_z", Z, 1'b0);
    put(1'b1, AND_, 16'hFFFF); tick();
    VI = 1'b0; CLR = 1'b1; tick(); chk("zs_set_wins", ZS, 1'b1);
    tick(); chk("zs_clr", ZS, 1'b0);
    CLR = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
